// File: rtl/bmp_stream_loader.sv
// BMP byte-stream parser that writes xRGB pixels to an SDRAM word port via toggle req/ack.
// Define BMP_RGB565_EN to also accept 16bpp (RGB555 / RGB565) images.
module bmp_stream_loader #(
  parameter int ADDR_W    = 21,
  parameter int BASE_ADDR = 0,
  parameter int FB_STRIDE = 640,
  parameter int MAX_W     = 640,
  parameter int MAX_H     = 312,
  parameter int INDEX     = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_d,
  output logic              busy,
  output logic              bmp_loaded,
  output logic              bmp_error,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SKIP, S_PIXELS, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic              wr_q, dl_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_d_q;
  logic              busy_q, loaded_q, error_q;
  logic [15:0]       img_w_q, img_h_q;

  logic              magic_ok_q;
  logic [31:0]       offset_q, width_q, height_q;
  logic [15:0]       bpp_q;
  logic [23:0]       comp_q;

  logic [31:0]       abs_h_q, x_q, row_q;
  logic              h_neg_q;
  logic [1:0]        bpb_m1_q, pad_q, bip_q, pad_left_q;
  logic              in_pad_q;
  logic [7:0]        b_q, g_q, r_q;

  logic              hold_valid_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [31:0]       hold_data_q;

`ifdef BMP_RGB565_EN
  logic              is16_q, rgb565_q;
  logic [15:0]       p16;
`endif

  logic              byte_stb, start, dl_fall;
  logic              hdr_last, fmt_ok, hdr_ok;
  logic [31:0]       comp_full, abs_h_calc, y_calc;
  logic              rows_done, pix_act, pix_done, keep;
  logic              issue, hold_free;
  logic [7:0]        red_byte;
  logic [31:0]       pix_word;
  logic [ADDR_W-1:0] pix_addr;

  assign byte_stb   = ioctl_wr & ~wr_q;
  assign start      = ioctl_download & ~dl_q & (ioctl_index == 8'(INDEX));
  assign dl_fall    = ~ioctl_download & dl_q;

  assign hdr_last   = (state_q == S_HEADER) && byte_stb && (ioctl_addr == 27'd33);
  assign comp_full  = {ioctl_dout, comp_q};
  assign abs_h_calc = height_q[31] ? (~height_q + 32'd1) : height_q;
  assign hdr_ok     = magic_ok_q && fmt_ok && (width_q != 32'd0) && (height_q != 32'd0) &&
                      (offset_q >= 32'd34);

  always_comb begin
    fmt_ok = 1'b0;
    if ((bpp_q == 16'd24 || bpp_q == 16'd32) && comp_full == 32'd0) fmt_ok = 1'b1;
`ifdef BMP_RGB565_EN
    if (bpp_q == 16'd16 && (comp_full == 32'd0 || comp_full == 32'd3)) fmt_ok = 1'b1;
`endif
  end

  // The byte sitting exactly at the data offset is already the first pixel byte.
  assign rows_done = (row_q == abs_h_q);
  assign pix_act   = byte_stb && !rows_done &&
                     ((state_q == S_SKIP && {5'd0, ioctl_addr} == offset_q) || state_q == S_PIXELS);
  assign pix_done  = pix_act && !in_pad_q && (bip_q == bpb_m1_q);
  assign y_calc    = h_neg_q ? row_q : (abs_h_q - 32'd1 - row_q);
  assign keep      = pix_done && (x_q < 32'(MAX_W)) && (y_calc < 32'(MAX_H));
  assign pix_addr  = ADDR_W'(32'(BASE_ADDR) + y_calc * 32'(FB_STRIDE) + x_q);

  assign issue     = hold_valid_q && (mem_req_q == mem_ack);
  assign hold_free = !hold_valid_q || issue;

  always_comb begin
    red_byte = (bip_q == 2'd2) ? ioctl_dout : r_q;
    pix_word = {8'h00, red_byte, g_q, b_q};
`ifdef BMP_RGB565_EN
    p16 = {ioctl_dout, b_q};
    if (is16_q) begin
      if (rgb565_q)
        pix_word = {8'h00, p16[15:11], p16[15:13], p16[10:5], p16[10:9], p16[4:0], p16[4:2]};
      else
        pix_word = {8'h00, p16[14:10], p16[14:12], p16[9:5], p16[9:7], p16[4:0], p16[4:2]};
    end
`endif
  end

  // A byte in the same cycle as the download fall is handled first, so the fall acts on its result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HEADER: if (hdr_last) state_d = hdr_ok ? S_SKIP : S_ERROR;
      S_SKIP:   if (pix_act) state_d = S_PIXELS;
      S_DRAIN:  if (!hold_valid_q && mem_req_q == mem_ack) state_d = S_DONE;
      default:  state_d = state_q;
    endcase
    if (dl_fall) begin
      if (state_d == S_HEADER) state_d = S_ERROR;
      else if (state_d == S_SKIP || state_d == S_PIXELS) state_d = S_DRAIN;
    end
    if (start) state_d = S_HEADER;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= ioctl_wr;
      dl_q         <= ioctl_download;
      mem_req_q    <= mem_ack;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      error_q      <= 1'b0;
      img_w_q      <= '0;
      img_h_q      <= '0;
      magic_ok_q   <= 1'b0;
      offset_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      bpp_q        <= '0;
      comp_q       <= '0;
      abs_h_q      <= '0;
      x_q          <= '0;
      row_q        <= '0;
      h_neg_q      <= 1'b0;
      bpb_m1_q     <= '0;
      pad_q        <= '0;
      bip_q        <= '0;
      pad_left_q   <= '0;
      in_pad_q     <= 1'b0;
      b_q          <= '0;
      g_q          <= '0;
      r_q          <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
`ifdef BMP_RGB565_EN
      is16_q       <= 1'b0;
      rgb565_q     <= 1'b0;
`endif
    end else begin
      wr_q    <= ioctl_wr;
      dl_q    <= ioctl_download;
      state_q <= state_d;
      busy_q  <= (state_d == S_HEADER) || (state_d == S_SKIP) || (state_d == S_PIXELS);

      if (start) begin
        loaded_q <= 1'b0;
        error_q  <= 1'b0;
      end

      // Multi-byte header fields are shifted in from the top, yielding little-endian order.
      if (state_q == S_HEADER && byte_stb) begin
        if (ioctl_addr == 27'd0) magic_ok_q <= (ioctl_dout == 8'h42);
        if (ioctl_addr == 27'd1) magic_ok_q <= magic_ok_q && (ioctl_dout == 8'h4D);
        if (ioctl_addr >= 27'd10 && ioctl_addr <= 27'd13) offset_q <= {ioctl_dout, offset_q[31:8]};
        if (ioctl_addr >= 27'd18 && ioctl_addr <= 27'd21) width_q  <= {ioctl_dout, width_q[31:8]};
        if (ioctl_addr >= 27'd22 && ioctl_addr <= 27'd25) height_q <= {ioctl_dout, height_q[31:8]};
        if (ioctl_addr >= 27'd28 && ioctl_addr <= 27'd29) bpp_q    <= {ioctl_dout, bpp_q[15:8]};
        if (ioctl_addr >= 27'd30 && ioctl_addr <= 27'd32) comp_q   <= {ioctl_dout, comp_q[23:8]};
      end

      if (hdr_last && hdr_ok) begin
        abs_h_q    <= abs_h_calc;
        h_neg_q    <= height_q[31];
        bpb_m1_q   <= (bpp_q == 16'd32) ? 2'd3 : (bpp_q == 16'd24) ? 2'd2 : 2'd1;
        pad_q      <= (bpp_q == 16'd24) ? width_q[1:0] :
                      (bpp_q == 16'd32) ? 2'd0 : {width_q[0], 1'b0};
        img_w_q    <= (width_q[31:16] != 16'd0) ? 16'hFFFF : width_q[15:0];
        img_h_q    <= (abs_h_calc[31:16] != 16'd0) ? 16'hFFFF : abs_h_calc[15:0];
        x_q        <= '0;
        row_q      <= '0;
        bip_q      <= '0;
        in_pad_q   <= 1'b0;
`ifdef BMP_RGB565_EN
        is16_q     <= (bpp_q == 16'd16);
        rgb565_q   <= (comp_full == 32'd3);
`endif
      end

      if (pix_act) begin
        if (in_pad_q) begin
          if (pad_left_q == 2'd1) begin
            in_pad_q <= 1'b0;
            row_q    <= row_q + 32'd1;
          end
          pad_left_q <= pad_left_q - 2'd1;
        end else begin
          case (bip_q)
            2'd0:    b_q <= ioctl_dout;
            2'd1:    g_q <= ioctl_dout;
            2'd2:    r_q <= ioctl_dout;
            default: ;
          endcase
          if (bip_q == bpb_m1_q) begin
            bip_q <= 2'd0;
            if (x_q == width_q - 32'd1) begin
              x_q <= '0;
              if (pad_q == 2'd0) begin
                row_q <= row_q + 32'd1;
              end else begin
                in_pad_q   <= 1'b1;
                pad_left_q <= pad_q;
              end
            end else begin
              x_q <= x_q + 32'd1;
            end
          end else begin
            bip_q <= bip_q + 2'd1;
          end
        end
      end

      // Holding register refills in the same cycle it hands off to the write port.
      if (keep) begin
        if (hold_free) begin
          hold_valid_q <= 1'b1;
          hold_addr_q  <= pix_addr;
          hold_data_q  <= pix_word;
        end else begin
          error_q <= 1'b1;
        end
      end else if (issue) begin
        hold_valid_q <= 1'b0;
      end

      if (issue) begin
        mem_req_q  <= ~mem_req_q;
        mem_addr_q <= hold_addr_q;
        mem_d_q    <= hold_data_q;
      end

      if (state_d == S_ERROR && state_q != S_ERROR) begin
        error_q  <= 1'b1;
        loaded_q <= 1'b0;
      end
      if (state_q == S_DRAIN && state_d == S_DONE) loaded_q <= !error_q;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_d      = mem_d_q;
  assign busy       = busy_q;
  assign bmp_loaded = loaded_q;
  assign bmp_error  = error_q;
  assign img_width  = img_w_q;
  assign img_height = img_h_q;

endmodule
